// File: rtl/rvv_issue_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvv_issue_tx_pkg
//  Description : Shared RVV issue types, lane counts and the prefix
//                handshake counter used by the issue transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvv_issue_tx_pkg;

    // Lanes presented toward the command queue per cycle
    localparam int ISSUE_LANE  = 4;
    // Instructions the scalar decode stage can hand over per cycle
    localparam int NUM_DE_INST = 2;
    // Width of a lane count (0..ISSUE_LANE inclusive)
    localparam int LANE_CNT_W  = $clog2(ISSUE_LANE + 1);

    // Opaque vector instruction word carried through the queue
    typedef logic [31:0] INST_t;

    // Number of consecutive ones starting at bit 0; counting stops at the
    // first zero so that only an in-order prefix of lanes is ever retired.
    function automatic logic [LANE_CNT_W-1:0] leading_ones_cnt(
        input logic [ISSUE_LANE-1:0] vec
    );
        logic [LANE_CNT_W-1:0] cnt;
        logic                  broken;
        cnt    = '0;
        broken = 1'b0;
        for (int i = 0; i < ISSUE_LANE; i++) begin
            if (!broken && vec[i]) begin
                cnt = cnt + LANE_CNT_W'(1);
            end else begin
                broken = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage : rvv_issue_tx_pkg
`default_nettype wire

// File: rtl/rvv_multiport_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rvv_multiport_fifo
//  Description : Circular instruction buffer with a variable-count push of
//                up to IN_LANES and a variable-count pop of up to OUT_LANES
//                per cycle. Flush clears pointers and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvv_multiport_fifo
    import rvv_issue_tx_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IN_LANES  = 2,
    parameter int OUT_LANES = ISSUE_LANE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic [LANE_CNT_W-1:0]        i_push_cnt,
    input  INST_t                        i_push_data [IN_LANES],
    input  logic [LANE_CNT_W-1:0]        i_pop_cnt,
    output INST_t                        o_rd_data   [OUT_LANES],
    output logic [$clog2(DEPTH):0]       o_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    INST_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [PTR_W-1:0]   w_wr_idx [IN_LANES];
    logic [PTR_W-1:0]   w_rd_idx [OUT_LANES];

    // Per-lane memory addresses; power-of-two depth makes the wrap free
    always_comb begin
        for (int j = 0; j < IN_LANES; j++) begin
            w_wr_idx[j] = r_wr_ptr + PTR_W'(j);
        end
        for (int i = 0; i < OUT_LANES; i++) begin
            w_rd_idx[i] = r_rd_ptr + PTR_W'(i);
        end
    end

    // Read lanes: oldest entry always on lane 0, lanes may straddle the wrap
    always_comb begin
        for (int i = 0; i < OUT_LANES; i++) begin
            o_rd_data[i] = r_mem[w_rd_idx[i]];
        end
    end

    // Storage array: only the accepted push prefix is written
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            for (int j = 0; j < IN_LANES; j++) begin
                if (LANE_CNT_W'(j) < i_push_cnt) begin
                    r_mem[w_wr_idx[j]] <= i_push_data[j];
                end
            end
        end
    end

    // Pointers and occupancy; flush wins over any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_cnt);
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_cnt);
            r_cnt    <= r_cnt + CNT_W'(i_push_cnt) - CNT_W'(i_pop_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule : rvv_multiport_fifo
`default_nettype wire

// File: rtl/rvv_issue_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rvv_issue_tx
//  Description : RVS-side transmitter toward the RVV command queue. Buffers
//                dispatched vector instructions, presents the oldest ones in
//                program order and retires the contiguous accepted prefix.
//                Trap stop holds state, trap flush discards it.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvv_issue_tx
    import rvv_issue_tx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int IN_LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_LANES-1:0]     push_valid,
    input  INST_t                   push_inst          [IN_LANES],
    output logic [IN_LANES-1:0]     push_ready,
    output logic [ISSUE_LANE-1:0]   insts_valid_rvs2cq,
    output INST_t                   insts_rvs2cq       [ISSUE_LANE],
    input  logic [ISSUE_LANE-1:0]   insts_ready_cq2rvs,
    input  logic                    stop_cmdq_wb2if,
    input  logic                    flush_cmdq_wb2if,
    output logic [$clog2(DEPTH):0]  pend_cnt,
    output logic                    idle
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   w_gate;
    logic [CNT_W-1:0]       w_cnt;
    logic [CNT_W-1:0]       w_free;
    logic [IN_LANES-1:0]    w_push_hs;
    logic [ISSUE_LANE-1:0]  w_pop_hs;
    logic [LANE_CNT_W-1:0]  w_n_push;
    logic [LANE_CNT_W-1:0]  w_n_pop;

    // Reset, trap stop and trap flush all silence both handshake sides
    assign w_gate = rst | stop_cmdq_wb2if | flush_cmdq_wb2if;

    // Free slots come from the registered count only, no credit from pops
    assign w_free = CNT_W'(DEPTH) - w_cnt;

    // Output lane valids: one per held entry, oldest on lane 0
    always_comb begin
        for (int i = 0; i < ISSUE_LANE; i++) begin
            insts_valid_rvs2cq[i] = (w_cnt > CNT_W'(i)) && !w_gate;
        end
    end

    // Push readiness: a lane is offered space only if every lower lane is valid
    always_comb begin
        logic lower_ok;
        lower_ok = 1'b1;
        for (int j = 0; j < IN_LANES; j++) begin
            push_ready[j] = lower_ok && (w_free > CNT_W'(j)) && !w_gate;
            lower_ok      = lower_ok && push_valid[j];
        end
    end

    // Prefix handshake counts on both sides
    always_comb begin
        w_push_hs = push_valid & push_ready;
        w_pop_hs  = insts_valid_rvs2cq & insts_ready_cq2rvs;
        w_n_push  = leading_ones_cnt(ISSUE_LANE'(w_push_hs));
        w_n_pop   = leading_ones_cnt(w_pop_hs);
    end

    rvv_multiport_fifo #(
        .DEPTH     (DEPTH),
        .IN_LANES  (IN_LANES),
        .OUT_LANES (ISSUE_LANE)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush_cmdq_wb2if),
        .i_push_cnt  (w_n_push),
        .i_push_data (push_inst),
        .i_pop_cnt   (w_n_pop),
        .o_rd_data   (insts_rvs2cq),
        .o_cnt       (w_cnt)
    );

    assign pend_cnt = w_cnt;
    assign idle     = (w_cnt == '0);

    // Occupancy stays within 0..DEPTH (an underflow wraps above DEPTH)
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (w_cnt + CNT_W'(w_n_push) - CNT_W'(w_n_pop)) <= CNT_W'(DEPTH));

    // No handshake while reset, stop or flush is asserted
    a_no_hs_gated: assert property (@(posedge clk)
        w_gate |-> (w_pop_hs == '0 && w_push_hs == '0));

endmodule : rvv_issue_tx
`default_nettype wire

// File: tb/tb_rvv_issue_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvv_issue_tx
//  Description : Directed and scoreboard-checked bench for rvv_issue_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvv_issue_tx;
    import rvv_issue_tx_pkg::*;

    localparam int DEPTH    = 8;
    localparam int IN_LANES = 2;

    logic                  clk;
    logic                  rst;
    logic [IN_LANES-1:0]   push_valid;
    INST_t                 push_inst [IN_LANES];
    logic [IN_LANES-1:0]   push_ready;
    logic [ISSUE_LANE-1:0] insts_valid_rvs2cq;
    INST_t                 insts_rvs2cq [ISSUE_LANE];
    logic [ISSUE_LANE-1:0] insts_ready_cq2rvs;
    logic                  stop_cmdq_wb2if;
    logic                  flush_cmdq_wb2if;
    logic [3:0]            pend_cnt;
    logic                  idle;

    int n_total;
    int n_bad;

    rvv_issue_tx #(
        .DEPTH    (DEPTH),
        .IN_LANES (IN_LANES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .push_valid         (push_valid),
        .push_inst          (push_inst),
        .push_ready         (push_ready),
        .insts_valid_rvs2cq (insts_valid_rvs2cq),
        .insts_rvs2cq       (insts_rvs2cq),
        .insts_ready_cq2rvs (insts_ready_cq2rvs),
        .stop_cmdq_wb2if    (stop_cmdq_wb2if),
        .flush_cmdq_wb2if   (flush_cmdq_wb2if),
        .pend_cnt           (pend_cnt),
        .idle               (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic INST_t ival(input int base, input int n);
        return INST_t'(base + n);
    endfunction

    // Scoreboard state for the streaming phase
    INST_t q[$];

    initial begin
        int seq;
        int recv;
        int cycles;
        INST_t saved;

        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        push_valid = '0;
        push_inst[0] = '0;
        push_inst[1] = '0;
        insts_ready_cq2rvs = '0;
        stop_cmdq_wb2if  = 1'b0;
        flush_cmdq_wb2if = 1'b0;

        // ---- reset state, with push lanes valid to prove they are gated
        #2;
        push_valid = 2'b11;
        insts_ready_cq2rvs = 4'b1111;
        #1;
        chk("rst_valid", 64'(insts_valid_rvs2cq), 64'h0);
        chk("rst_pready", 64'(push_ready), 64'h0);
        chk("rst_pend", 64'(pend_cnt), 64'h0);
        chk("rst_idle", 64'(idle), 64'h1);
        cyc();
        cyc();
        rst = 1'b0;

        // ---- test 1: push A,B then pop both
        insts_ready_cq2rvs = '0;
        push_valid   = 2'b11;
        push_inst[0] = 32'hAAAA_0000;
        push_inst[1] = 32'hBBBB_0000;
        #2;
        chk("t1_pready", 64'(push_ready), 64'h3);
        cyc();
        push_valid = '0;
        insts_ready_cq2rvs = 4'b1111;
        #2;
        chk("t1_valid", 64'(insts_valid_rvs2cq), 64'h3);
        chk("t1_lane0", 64'(insts_rvs2cq[0]), 64'hAAAA_0000);
        chk("t1_lane1", 64'(insts_rvs2cq[1]), 64'hBBBB_0000);
        chk("t1_pend2", 64'(pend_cnt), 64'h2);
        cyc();
        insts_ready_cq2rvs = '0;
        #2;
        chk("t1_pend0", 64'(pend_cnt), 64'h0);
        chk("t1_idle", 64'(idle), 64'h1);

        // ---- test 2: fill to full with no readiness
        for (int k = 0; k < 4; k++) begin
            push_valid   = 2'b11;
            push_inst[0] = ival(32'h1000_0000, 2 * k);
            push_inst[1] = ival(32'h1000_0000, 2 * k + 1);
            cyc();
        end
        push_valid = 2'b11;
        #2;
        chk("t2_pend", 64'(pend_cnt), 64'h8);
        chk("t2_pready", 64'(push_ready), 64'h0);
        chk("t2_valid", 64'(insts_valid_rvs2cq), 64'hF);
        for (int i = 0; i < 4; i++) begin
            chk("t2_lane", 64'(insts_rvs2cq[i]), 64'(ival(32'h1000_0000, i)));
        end

        // ---- test 3: partial pop at full, then non-prefix ready
        push_valid = '0;
        insts_ready_cq2rvs = 4'b0011;
        cyc();
        insts_ready_cq2rvs = 4'b1100;
        push_valid = 2'b11;
        #2;
        chk("t3_lane0", 64'(insts_rvs2cq[0]), 64'h1000_0002);
        chk("t3_pend6", 64'(pend_cnt), 64'h6);
        chk("t3_pready", 64'(push_ready), 64'h3);
        push_valid = '0;
        cyc();
        #2;
        chk("t3_hold", 64'(pend_cnt), 64'h6);
        chk("t3_lane0b", 64'(insts_rvs2cq[0]), 64'h1000_0002);
        insts_ready_cq2rvs = 4'b1111;
        cyc();
        cyc();
        insts_ready_cq2rvs = '0;
        #2;
        chk("t3_drain", 64'(pend_cnt), 64'h0);

        // ---- test 4: random stream against a scoreboard
        seq    = 0;
        recv   = 0;
        cycles = 0;
        q.delete();
        while (recv < 40 && cycles < 600) begin
            logic [IN_LANES-1:0]   pv;
            logic [ISSUE_LANE-1:0] rdy;
            logic [IN_LANES-1:0]   exp_pr;
            logic [ISSUE_LANE-1:0] exp_v;
            int free;
            int npush;
            int npop;

            pv  = IN_LANES'($urandom_range(0, 3));
            rdy = ISSUE_LANE'($urandom_range(0, 15));
            if (seq >= 40) pv = '0;
            else if (seq == 39) pv = pv & 2'b01;
            push_valid   = pv;
            push_inst[0] = ival(32'h3000_0000, seq);
            push_inst[1] = ival(32'h3000_0000, seq + 1);
            insts_ready_cq2rvs = rdy;
            #2;

            free = DEPTH - q.size();
            exp_pr[0] = (free > 0);
            exp_pr[1] = (free > 1) && pv[0];
            for (int i = 0; i < ISSUE_LANE; i++) exp_v[i] = (q.size() > i);
            chk("t4_pend", 64'(pend_cnt), 64'(q.size()));
            chk("t4_valid", 64'(insts_valid_rvs2cq), 64'(exp_v));
            chk("t4_pready", 64'(push_ready), 64'(exp_pr));
            for (int i = 0; i < ISSUE_LANE; i++) begin
                if (i < q.size()) chk("t4_lane", 64'(insts_rvs2cq[i]), 64'(q[i]));
            end

            npop = 0;
            while (npop < ISSUE_LANE && npop < q.size() && rdy[npop]) npop++;
            npush = 0;
            if (pv[0] && exp_pr[0]) begin
                npush = 1;
                if (pv[1] && exp_pr[1]) npush = 2;
            end
            for (int i = 0; i < npop; i++) void'(q.pop_front());
            recv += npop;
            for (int j = 0; j < npush; j++) q.push_back(ival(32'h3000_0000, seq + j));
            seq += npush;
            cycles++;
            cyc();
        end
        push_valid = '0;
        insts_ready_cq2rvs = '0;
        chk("t4_done", 64'(recv), 64'd40);
        #2;
        chk("t4_empty", 64'(pend_cnt), 64'h0);

        // ---- test 5: stop holds state and resumes at the same instruction
        for (int k = 0; k < 3; k++) begin
            push_valid   = (k == 2) ? 2'b01 : 2'b11;
            push_inst[0] = ival(32'h2000_0000, 2 * k);
            push_inst[1] = ival(32'h2000_0000, 2 * k + 1);
            cyc();
        end
        push_valid = '0;
        #2;
        chk("t5_pend", 64'(pend_cnt), 64'h5);
        saved = 32'h2000_0000;
        stop_cmdq_wb2if = 1'b1;
        insts_ready_cq2rvs = 4'b1111;
        push_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_valid", 64'(insts_valid_rvs2cq), 64'h0);
            chk("t5_pready", 64'(push_ready), 64'h0);
            chk("t5_hold", 64'(pend_cnt), 64'h5);
            cyc();
        end
        stop_cmdq_wb2if = 1'b0;
        insts_ready_cq2rvs = '0;
        push_valid = '0;
        #2;
        chk("t5_resume", 64'(insts_rvs2cq[0]), 64'(saved));
        chk("t5_rvalid", 64'(insts_valid_rvs2cq), 64'hF);
        chk("t5_rpend", 64'(pend_cnt), 64'h5);

        // ---- test 6: flush with pushes and readies, then async reset
        flush_cmdq_wb2if = 1'b1;
        push_valid = 2'b11;
        insts_ready_cq2rvs = 4'b1111;
        #1;
        chk("t6_valid", 64'(insts_valid_rvs2cq), 64'h0);
        chk("t6_pready", 64'(push_ready), 64'h0);
        cyc();
        flush_cmdq_wb2if = 1'b0;
        push_valid = '0;
        insts_ready_cq2rvs = '0;
        #2;
        chk("t6_pend", 64'(pend_cnt), 64'h0);
        chk("t6_idle", 64'(idle), 64'h1);
        chk("t6_nvalid", 64'(insts_valid_rvs2cq), 64'h0);

        push_valid   = 2'b11;
        push_inst[0] = 32'h4000_0000;
        push_inst[1] = 32'h4000_0001;
        cyc();
        push_valid = '0;
        #2;
        chk("t6_prerst", 64'(insts_valid_rvs2cq), 64'h3);
        chk("t6_lane0", 64'(insts_rvs2cq[0]), 64'h4000_0000);
        rst = 1'b1;
        push_valid = 2'b11;
        #1;
        chk("t6_rvalid", 64'(insts_valid_rvs2cq), 64'h0);
        chk("t6_rpend", 64'(pend_cnt), 64'h0);
        chk("t6_ridle", 64'(idle), 64'h1);
        chk("t6_rpready", 64'(push_ready), 64'h0);
        cyc();
        rst = 1'b0;
        push_valid = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rvv_issue_tx
`default_nettype wire
